slow_clock_monitor: RTL

- Receive-side counterpart of the 1 Hz clock divider.
- Takes a slow divided clock (free-running, asynchronous to the fast domain) and synchronises it into the 100 MHz cin domain.
- Emits a one-cycle tick per rising edge, measures each period in cin cycles, and flags out-of-range or stalled slow clocks.
- Consumers: game sequencing logic (dice roll timing, display blink) and a bring-up LED.

---
 rtl/craps_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 40 ++++
 rtl/slow_clock_monitor.sv | 98 +++++++++
 3 files changed

// File: rtl/craps_pkg.sv
// Shared constants and types for the craps game clocking blocks.
// Latency: none (declarations only).
// Backpressure: not applicable.
package craps_pkg;

    // Fast system clock frequency; the slow clock under observation nominally runs at 1 Hz.
    localparam int unsigned CLK_HZ = 100_000_000;

    // Declare a stall after two nominal seconds without a slow edge.
    localparam int unsigned DEF_TIMEOUT_CYCLES = 2 * CLK_HZ;

    // Accept periods within +/-10 % of nominal.
    localparam int unsigned DEF_MIN_PERIOD = (CLK_HZ / 10) * 9;
    localparam int unsigned DEF_MAX_PERIOD = (CLK_HZ / 10) * 11;

    // Number of cycles after reset release before edge detection is armed. The s1/s2/s2_d
    // pipeline holds reset zeros until all three flops carry post-reset samples; arming any
    // earlier would report a high-at-release input as a rising edge.
    localparam logic [1:0] SYNC_WARMUP = 2'd3;

    // Slow clock monitor state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser with rising-edge detector and post-reset warmup gate.
// Latency: input rise sampled at edge k -> rise high between edges k+1 and k+2 (combinational).
// Backpressure: none; pulses shorter than one clock period may be missed.
module sync_edge_detect
    import craps_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic       s1;
    logic       s2;
    logic       s2_d;
    logic [1:0] warm;
    logic       armed;

    assign armed = (warm == SYNC_WARMUP);

    // Synchroniser pipeline, previous-value flop, and saturating warmup counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
            warm <= 2'd0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s2_d <= s2;
            if (!armed) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign rise = armed & s2 & ~s2_d;

endmodule

// File: rtl/slow_clock_monitor.sv
// Monitors a slow asynchronous clock: tick per rise, period measurement, range and stall flags.
// Latency: slow_clk rise sampled at edge k -> tick/period_valid registered at edge k+2.
// Backpressure: none; outputs are pulses/levels that consumers must sample as they occur.
module slow_clock_monitor
    import craps_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MIN_PERIOD     = DEF_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD     = DEF_MAX_PERIOD
) (
    input  logic             cin,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             stalled,
    output logic [7:0]       tick_count
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PERIOD);

    logic             rise;
    logic [CNT_W-1:0] cnt;
    mon_state_e       state;

    sync_edge_detect u_sync (
        .clk   (cin),
        .rst_n (rst_n),
        .din   (slow_clk),
        .rise  (rise)
    );

    // Cycles since the last qualified edge; restarts at 1 on an edge and saturates rather than wrapping.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Monitor FSM with registered outputs; an edge takes priority over the stall threshold.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tick         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            in_range     <= 1'b0;
            stalled      <= 1'b0;
            tick_count   <= 8'd0;
        end else begin
            tick         <= rise;
            period_valid <= 1'b0;
            if (rise) begin
                tick_count <= tick_count + 8'd1;
            end
            case (state)
                IDLE: begin
                    // First edge only opens a measurement window.
                    if (rise) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        in_range     <= (cnt >= MIN_C) && (cnt <= MAX_C);
                    end else if (cnt >= TIMEOUT_C) begin
                        state   <= STALL;
                        stalled <= 1'b1;
                    end
                end
                STALL: begin
                    // Recovery edge restarts the measurement; period and in_range keep stale values.
                    if (rise) begin
                        state   <= RUN;
                        stalled <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
